// File: rtl/fp_add_sched.sv
// Round-robin front end that shares one fixed-latency pipelined FP adder among
// several requesters, with a shadow tag pipeline and a credit-protected result FIFO.
// Latency: accept edge k -> response valid from cycle k+LAT+1 (FIFO empty).
// Backpressure: req_ready drops while in-flight ops plus FIFO entries reach FIFO_DEPTH.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       per-requester handshake; req_ready is one-hot or zero
//   req_a, req_b              packed operands, requester i at [32i+31:32i]
//   add_a, add_b, add_result  connection to the external pipelined adder
//   rsp_valid/rsp_ready       single response channel, global issue order
//   rsp_data, rsp_id          sum and originating requester
//   busy                      any op in flight or any result waiting

// Generic circular FIFO, any depth (pointers wrap explicitly, not by overflow).
// Latency: written entry is visible at the head the cycle after the write edge.
// Backpressure: none internally; the writer must guarantee space before writing.
module fp_add_sched_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 16,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_vld,
   input  logic [W-1:0]  wr_dat,
   input  logic          rd_rdy,
   output logic          rd_vld,
   output logic [W-1:0]  rd_dat,
   output logic [CW-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          rd_pop;

   // Explicit wrap so that non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign rd_vld = (count_q != '0);
   assign rd_dat = mem_q[rd_ptr_q];
   assign count  = count_q;
   assign rd_pop = rd_vld & rd_rdy;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_vld) begin
         mem_d[wr_ptr_q] = wr_dat;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (rd_pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      unique case ({wr_vld, rd_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage is reset too so the head reads as zero while empty after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// Round-robin adder scheduler top level.
// Latency: LAT+1 cycles from accept edge to response valid when the FIFO is empty.
// Backpressure: credit = FIFO_DEPTH minus (in-flight tags + FIFO entries); zero credit gates req_ready.
module fp_add_sched #(
   parameter int NREQ       = 4,
   parameter int LAT        = 6,
   parameter int FIFO_DEPTH = 16,
   parameter int IDW        = $clog2(NREQ)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [32*NREQ-1:0]  req_a,
   input  logic [32*NREQ-1:0]  req_b,
   output logic [31:0]         add_a,
   output logic [31:0]         add_b,
   input  logic [31:0]         add_result,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [31:0]         rsp_data,
   output logic [IDW-1:0]      rsp_id,
   output logic                busy
);

   localparam int FCW  = $clog2(FIFO_DEPTH + 1);
   localparam int IFW  = $clog2(LAT + 2);
   localparam int SUMW = ((FCW > IFW) ? FCW : IFW) + 1;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [31:0]    dat;
   } rsp_t;

   localparam int RSPW = $bits(rsp_t);

   // Round-robin pointer and operand registers feeding the adder.
   logic [IDW-1:0]        ptr_q, ptr_d;
   logic [31:0]           add_a_q, add_a_d;
   logic [31:0]           add_b_q, add_b_d;

   // Shadow tag pipeline t0..tLAT travelling alongside the adder.
   logic [LAT:0]          tag_vld_q, tag_vld_d;
   logic [LAT:0][IDW-1:0] tag_id_q, tag_id_d;

   logic                  grant_vld;
   logic [IDW-1:0]        grant_id;
   int unsigned           scan_idx;
   logic [IDW-1:0]        scan_id;
   logic [31:0]           sel_a;
   logic [31:0]           sel_b;
   logic [IFW-1:0]        inflight;
   logic [FCW-1:0]        fifo_count;
   logic                  can_issue;
   logic                  accept;
   logic                  fifo_wr_vld;
   rsp_t                  fifo_wr_dat;
   logic [RSPW-1:0]       fifo_rd_dat;
   rsp_t                  fifo_head;

   // Grant: first valid requester starting at ptr_q, wrapping.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = '0;
      scan_idx  = 0;
      scan_id   = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan_idx = (int'(ptr_q) + k) % NREQ;
         scan_id  = IDW'(scan_idx);
         if (!grant_vld && req_valid[scan_id]) begin
            grant_vld = 1'b1;
            grant_id  = scan_id;
         end
      end
   end

   // Operand mux for the granted requester.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_id == IDW'(i)) begin
            sel_a = req_a[32*i +: 32];
            sel_b = req_b[32*i +: 32];
         end
      end
   end

   // Every valid tag will land in the FIFO, so it already holds a credit.
   always_comb begin
      inflight = '0;
      for (int i = 0; i <= LAT; i++) begin
         inflight = inflight + IFW'(tag_vld_q[i]);
      end
   end

   assign can_issue = (SUMW'(inflight) + SUMW'(fifo_count)) < SUMW'(FIFO_DEPTH);
   assign accept    = grant_vld & can_issue & ~rst;

   // req_ready is combinational on req_valid through the grant; zero in reset.
   always_comb begin
      req_ready = '0;
      if (accept) begin
         req_ready[grant_id] = 1'b1;
      end
   end

   always_comb begin
      ptr_d   = ptr_q;
      add_a_d = add_a_q;
      add_b_d = add_b_q;
      if (accept) begin
         add_a_d = sel_a;
         add_b_d = sel_b;
         ptr_d   = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
      end
   end

   // The adder cannot stall, so the tags shift every cycle; bubbles carry {0,0}.
   always_comb begin
      tag_vld_d = {tag_vld_q[LAT-1:0], accept};
      tag_id_d  = {tag_id_q[LAT-1:0], (accept ? grant_id : IDW'(0))};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q     <= '0;
         add_a_q   <= '0;
         add_b_q   <= '0;
         tag_vld_q <= '0;
         tag_id_q  <= '0;
      end else begin
         ptr_q     <= ptr_d;
         add_a_q   <= add_a_d;
         add_b_q   <= add_b_d;
         tag_vld_q <= tag_vld_d;
         tag_id_q  <= tag_id_d;
      end
   end

   assign add_a = add_a_q;
   assign add_b = add_b_q;

   // tLAT valid means add_result holds that op's sum during this cycle.
   // The write is not guarded against full: the credit rule makes it impossible.
   assign fifo_wr_vld     = tag_vld_q[LAT];
   assign fifo_wr_dat.id  = tag_id_q[LAT];
   assign fifo_wr_dat.dat = add_result;

   fp_add_sched_fifo #(
      .W     (RSPW),
      .DEPTH (FIFO_DEPTH),
      .CW    (FCW)
   ) u_rsp_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr_vld (fifo_wr_vld),
      .wr_dat (fifo_wr_dat),
      .rd_rdy (rsp_ready),
      .rd_vld (rsp_valid),
      .rd_dat (fifo_rd_dat),
      .count  (fifo_count)
   );

   assign fifo_head = rsp_t'(fifo_rd_dat);
   assign rsp_data  = fifo_head.dat;
   assign rsp_id    = fifo_head.id;
   assign busy      = (inflight != '0) | (fifo_count != '0);

endmodule

// File: tb/tb_fp_add_sched.sv
// Bench for fp_add_sched: behavioural pipelined adder, per-cycle grant/credit model,
// and a scoreboard of expected {id, sum} pushed on accept and popped on response.
// Exits through one summary line.
module tb_fp_add_sched;

   localparam int NREQ       = 4;
   localparam int LAT        = 6;
   localparam int FIFO_DEPTH = 16;
   localparam int IDW        = 2;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [31:0]    dat;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [32*NREQ-1:0]  req_a;
   logic [32*NREQ-1:0]  req_b;
   logic [31:0]         add_a;
   logic [31:0]         add_b;
   logic [31:0]         add_result;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [31:0]         rsp_data;
   logic [IDW-1:0]      rsp_id;
   logic                busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int outst  = 0;
   int mptr   = 0;
   exp_t sb_q[$];
   int   acc_ids[$];
   int   pop_cyc[$];
   logic [NREQ-1:0] mon_exp_rdy;
   exp_t            mon_e;

   always #5 clk = ~clk;

   fp_add_sched #(
      .NREQ       (NREQ),
      .LAT        (LAT),
      .FIFO_DEPTH (FIFO_DEPTH),
      .IDW        (IDW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .add_a      (add_a),
      .add_b      (add_b),
      .add_result (add_result),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_id     (rsp_id),
      .busy       (busy)
   );

   // Single-precision add through double arithmetic; operands are small integers
   // so every sum is exact and no rounding mode question arises.
   function automatic real sp2r(input logic [31:0] x);
      logic [10:0] e;
      if (x[30:23] == 8'd0) return 0.0;
      e = {3'b000, x[30:23]} + 11'd896;
      return $bitstoreal({x[31], e, x[22:0], 29'd0});
   endfunction

   function automatic logic [31:0] r2sp(input real r);
      logic [63:0] d;
      logic [10:0] e;
      d = $realtobits(r);
      if (d[62:0] == 63'd0) return {d[63], 31'd0};
      e = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
      return r2sp(sp2r(a) + sp2r(b));
   endfunction

   function automatic logic [31:0] rnd_fp();
      int n;
      n = int'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) n = -n;
      return r2sp(real'(n));
   endfunction

   // Behavioural stand-in for the external adder: LAT register stages.
   logic [31:0] pipe [LAT];
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= fadd(add_a, add_b);
         for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
   end
   assign add_result = pipe[LAT-1];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while ((busy || rsp_valid) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_sb_empty"}, sb_q.size(), 0);
   endtask

   // One op on requester id; measures accept-to-valid latency and the head entry.
   task automatic single_op(input string tag, input int id, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_sum);
      int lat;
      logic got;
      logic [NREQ-1:0] oh;
      oh = NREQ'(1) << id;
      rsp_ready = 1'b0;
      set_op(id, a, b);
      req_valid = oh;
      @(negedge clk);
      check_eq({tag, "_ready"}, req_ready, oh);
      @(posedge clk);
      #1;
      req_valid = '0;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 20) begin
         @(negedge clk);
         if (rsp_valid) got = 1'b1;
         else begin
            @(posedge clk);
            lat++;
         end
      end
      check_eq({tag, "_latency"}, lat, LAT + 1);
      check_eq({tag, "_data"}, rsp_data, exp_sum);
      check_eq({tag, "_id"}, rsp_id, id);
      step();
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      @(negedge clk);
      check_eq({tag, "_busy_after_pop"}, busy, 0);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Per-cycle model: expected grant/credit, busy, and scoreboard push/pop.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            sb_q.delete();
            outst = 0;
            mptr  = 0;
         end else begin
            mon_exp_rdy = '0;
            if (outst < FIFO_DEPTH) begin
               for (int k = 0; k < NREQ; k++) begin
                  if (mon_exp_rdy == '0 && req_valid[(mptr + k) % NREQ])
                     mon_exp_rdy[(mptr + k) % NREQ] = 1'b1;
               end
            end
            check_eq("req_ready", req_ready, mon_exp_rdy);
            check_eq("busy", busy, (outst != 0));
            for (int i = 0; i < NREQ; i++) begin
               if (req_valid[i] && req_ready[i]) begin
                  mon_e.id  = IDW'(i);
                  mon_e.dat = fadd(req_a[32*i +: 32], req_b[32*i +: 32]);
                  sb_q.push_back(mon_e);
                  acc_ids.push_back(i);
                  mptr = (i + 1) % NREQ;
                  outst++;
               end
            end
            if (rsp_valid && sb_q.size() == 0) begin
               check_eq("rsp_spurious", rsp_valid, 0);
            end else if (rsp_valid && rsp_ready) begin
               mon_e = sb_q.pop_front();
               check_eq("rsp_id", rsp_id, mon_e.id);
               check_eq("rsp_data", rsp_data, mon_e.dat);
               pop_cyc.push_back(cyc);
               outst--;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NREQ-1:0] acc;
      int c;

      rst       = 1'b1;
      req_valid = '1;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      #12;
      check_eq("rst_req_ready", req_ready, 0);
      check_eq("rst_rsp_valid", rsp_valid, 0);
      check_eq("rst_rsp_data", rsp_data, 0);
      check_eq("rst_rsp_id", rsp_id, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_add_a", add_a, 0);
      check_eq("rst_add_b", add_b, 0);
      req_valid = '0;
      @(posedge clk);
      #2;
      rst = 1'b0;
      step();

      // Fairness: all requesters valid for 8 edges, pointer starts at 0.
      for (int i = 0; i < NREQ; i++) set_op(i, rnd_fp(), rnd_fp());
      rsp_ready = 1'b1;
      acc_ids.delete();
      pop_cyc.delete();
      req_valid = '1;
      repeat (8) step();
      req_valid = '0;
      wait_idle("fair");
      check_eq("fair_accepts", acc_ids.size(), 8);
      for (int i = 0; i < acc_ids.size(); i++) check_eq("fair_grant", acc_ids[i], i % NREQ);
      check_eq("fair_pops", pop_cyc.size(), 8);
      for (int i = 1; i < pop_cyc.size(); i++) check_eq("fair_pop_gap", pop_cyc[i] - pop_cyc[i-1], 1);

      // Single op: 1.0 + 2.0 on requester 2.
      step();
      single_op("single", 2, 32'h3F800000, 32'h40000000, 32'h40400000);

      // Backpressure: no drain, requester 0 always valid.
      step();
      acc_ids.delete();
      rsp_ready = 1'b0;
      set_op(0, 32'h41200000, 32'h3F800000);
      req_valid = 4'b0001;
      repeat (40) step();
      check_eq("bp_accepts", acc_ids.size(), FIFO_DEPTH);
      @(negedge clk);
      check_eq("bp_ready_low", req_ready, 0);
      step();
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      repeat (10) step();
      check_eq("bp_one_more", acc_ids.size(), FIFO_DEPTH + 1);
      @(negedge clk);
      check_eq("bp_ready_low2", req_ready, 0);
      step();
      req_valid = '0;
      rsp_ready = 1'b1;
      wait_idle("bp");

      // Wrap: 40 ops, random operands renewed on each accept, drain toggling every 3 cycles.
      step();
      acc_ids.delete();
      for (int i = 0; i < NREQ; i++) set_op(i, rnd_fp(), rnd_fp());
      req_valid = '1;
      c = 0;
      while (acc_ids.size() < 40 && c < 2000) begin
         rsp_ready = ((c / 3) % 2) == 0;
         @(negedge clk);
         acc = req_valid & req_ready;
         @(posedge clk);
         #1;
         c++;
         for (int i = 0; i < NREQ; i++) if (acc[i]) set_op(i, rnd_fp(), rnd_fp());
         if (acc_ids.size() >= 40) req_valid = '0;
      end
      req_valid = '0;
      check_eq("wrap_accepts", acc_ids.size(), 40);
      rsp_ready = 1'b1;
      wait_idle("wrap");

      // Pointer skip: only requester 3, then only requester 1.
      step();
      set_op(3, 32'h40400000, 32'h40400000);
      set_op(1, 32'h40800000, 32'h3F800000);
      req_valid = 4'b1000;
      @(negedge clk);
      check_eq("skip_grant3", req_ready, 4'b1000);
      step();
      req_valid = 4'b0010;
      @(negedge clk);
      check_eq("skip_grant1", req_ready, 4'b0010);
      step();
      req_valid = '0;
      rsp_ready = 1'b1;
      wait_idle("skip");

      // Reset mid-flight: five accepts, no drain, reset three cycles later.
      step();
      acc_ids.delete();
      rsp_ready = 1'b0;
      set_op(1, 32'h40E00000, 32'h3F800000);
      req_valid = 4'b0010;
      repeat (5) step();
      req_valid = '0;
      check_eq("mid_accepts", acc_ids.size(), 5);
      repeat (3) @(posedge clk);
      #3;
      req_valid = '1;
      rst = 1'b1;
      #1;
      check_eq("mid_rst_req_ready", req_ready, 0);
      check_eq("mid_rst_rsp_valid", rsp_valid, 0);
      check_eq("mid_rst_rsp_data", rsp_data, 0);
      check_eq("mid_rst_rsp_id", rsp_id, 0);
      check_eq("mid_rst_busy", busy, 0);
      check_eq("mid_rst_add_a", add_a, 0);
      req_valid = '0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b0;
      rsp_ready = 1'b1;
      repeat (20) step();
      check_eq("mid_no_rsp", rsp_valid, 0);
      single_op("post_rst", 0, 32'h40A00000, 32'h3F800000, 32'h40C00000);
      wait_idle("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_add_sched.md
# fp_add_sched

Round-robin scheduler that shares one pipelined IEEE single-precision adder (`IEEE_SP_FP_ADDER`, fixed latency, no valid/ready of its own) among `NREQ` requesters. Requesters offer operand pairs with valid/ready handshakes; the block issues at most one pair per cycle and carries a shadow tag pipeline alongside the adder. A credit-protected result FIFO returns each sum with its requester ID on a single valid/ready response channel, in global issue order.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `LAT`, 6, cycles from operands on `add_a`/`add_b` to the matching sum on `add_result`
- `FIFO_DEPTH`, 16, result FIFO entries (≥ 2)
- `IDW`, $clog2(NREQ), requester ID width
- `clk` in 1, clock; all state on rising edge
- `rst` in 1, asynchronous, active-high reset
- `req_valid` in NREQ, per-requester operand valid
- `req_ready` out NREQ, per-requester accept (one-hot or zero)
- `req_a` in 32*NREQ, operand A; requester i at [32i+31:32i]
- `req_b` in 32*NREQ, operand B, same packing
- `add_a` out 32, to adder `Number1`
- `add_b` out 32, to adder `Number2`
- `add_result` in 32, from adder `Result`
- `rsp_valid` out 1, response valid
- `rsp_ready` in 1, response accept
- `rsp_data` out 32, sum
- `rsp_id` out IDW, requester that issued the sum
- `busy` out 1, any op in flight or FIFO non-empty

## Operation
- Round-robin pointer `ptr` (reset 0). Grant = first i in ptr, ptr+1, …, wrapping, with `req_valid[i]`=1.
- `can_issue` = (`inflight` + `fifo_count`) < FIFO_DEPTH; `inflight` = number of valid tags in t0..tLAT.
- `req_ready[grant]` = `can_issue`; all other bits 0; all bits 0 during reset. `req_ready` may depend combinationally on `req_valid`; requesters must not make `req_valid` depend on `req_ready`.
- Accept (valid & ready at an edge): `add_a`/`add_b` register the granted `req_a`/`req_b`; t0 ← {1, grant id}; `ptr` ← grant+1 mod NREQ.
- No accept: `add_a`/`add_b` hold previous value; t0 ← {0, 0}; `ptr` unchanged.
- Tag pipeline t0..tLAT (LAT+1 registers) shifts every cycle unconditionally; the adder cannot stall.
- When tLAT is valid during a cycle, `add_result` is that op's sum; {`add_result`, id} is written into the FIFO at the end of that cycle. The credit rule guarantees the FIFO is never full at a write; a write into a full FIFO is a bench-flagged error.
- FIFO: circular, `wr_ptr`/`rd_ptr` wrap at FIFO_DEPTH (any value, not only powers of 2); simultaneous write and read allowed, `fifo_count` unchanged. `rsp_valid` = `fifo_count` ≠ 0; `rsp_data`/`rsp_id` = head entry, stable while `rsp_valid` & !`rsp_ready`. No bypass from tLAT to the response.
- `busy` = (`inflight` ≠ 0) | (`fifo_count` ≠ 0).
- Reset (asynchronous, any time): clear all tags, `ptr`, FIFO pointers and count; `add_a`=`add_b`=0; `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `busy`=0. In-flight sums are discarded. The adder is reset on the same `rst`.

## Timing
- Accept at edge k → t0 valid in cycle k → tLAT valid in cycle k+LAT → FIFO write at edge k+LAT+1 → `rsp_valid` from cycle k+LAT+1 (7 cycles with LAT=6) if FIFO was empty.
- Throughput: 1 accept/cycle while `can_issue`. Sustained 1/cycle with `rsp_ready`=1 needs FIFO_DEPTH ≥ LAT+3; the default meets this.
- With `rsp_ready`=0: at most FIFO_DEPTH accepts, then `req_ready`=0 until a pop. One freed credit is visible on the cycle after the pop edge.
- Response order equals accept order across all requesters.

## Test plan
- Single op: req 2 offers 0x3F800000 + 0x40000000 at edge k → `req_ready`=0b0100; `rsp_valid` at cycle k+7 with `rsp_data`=0x40400000, `rsp_id`=2; `busy` falls after the pop.
- Fairness: all 4 `req_valid` held high for 8 cycles, `rsp_ready`=1 → grants 0,1,2,3,0,1,2,3 on consecutive edges; responses return in that ID order, 1 per cycle.
- Backpressure: `rsp_ready`=0, req 0 always valid → exactly 16 accepts, then `req_ready` stays 0; one `rsp_ready` pulse → exactly one further accept, `fifo_count` back to 16.
- Wrap: 40 back-to-back ops with `rsp_ready` toggling 1/0 every 3 cycles → every response matches the model in order; no FIFO write when full; `busy`=0 after the last pop.
- Reset mid-flight: assert `rst` 3 cycles after 5 accepts → all outputs at reset values immediately; no response ever appears for those ops; the next accept after release yields a correct result with latency 7.
- Pointer skip: only req 3 then req 1 valid → grant 3, then `ptr`=0 and req 1 granted next cycle.
